// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared mode and direction encodings for param_count
package count_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/count_next.sv
// rtl/count_next.sv - combinational next-count, terminal hit and done-set
module count_next
  import count_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] next_count,
  output logic             tc_hit,
  output logic             done_set
);

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  always_comb begin
    next_count = count;
    done_set   = 1'b0;
    tc_hit     = (dir == DIR_UP) ? (count == MAX) : (count == ZERO);
    if (!tc_hit) begin
      next_count = (dir == DIR_UP) ? count + ONE : count - ONE;
    end else begin
      case (mode)
        MODE_RELOAD:  next_count = reload;
        MODE_ONESHOT: done_set   = 1'b1;
        // reserved mode is treated as wrap
        default:      next_count = (dir == DIR_UP) ? ZERO : MAX;
      endcase
    end
  end

endmodule

// File: rtl/param_count.sv
// rtl/param_count.sv - WIDTH-bit up/down counter with wrap/reload/one-shot terminal modes
module param_count
  import count_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] reload_o,
  output logic             tc_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] next_count;
  logic             tc_hit;
  logic             done_set;

  count_next #(.WIDTH(WIDTH)) u_next (
    .count      (count_o),
    .dir        (dir_i),
    .mode       (mode_i),
    .reload     (reload_o),
    .next_count (next_count),
    .tc_hit     (tc_hit),
    .done_set   (done_set)
  );

  // clear beats load beats step; a finished one-shot ignores en_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o  <= RST_W;
      reload_o <= RST_W;
      tc_o     <= 1'b0;
      done_o   <= 1'b0;
    end else if (clr_i) begin
      count_o <= '0;
      tc_o    <= 1'b0;
      done_o  <= 1'b0;
    end else if (load_i) begin
      count_o  <= load_val_i;
      reload_o <= load_val_i;
      tc_o     <= 1'b0;
      done_o   <= 1'b0;
    end else if (en_i && !done_o) begin
      count_o <= next_count;
      tc_o    <= tc_hit;
      done_o  <= done_set;
    end else begin
      tc_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_count.sv
// tb/tb_param_count.sv - table-driven scoreboard bench for param_count (WIDTH=4)
module tb_param_count;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_i, load_i, en_i, dir_i;
  logic [3:0] load_val_i;
  logic [1:0] mode_i;
  logic [3:0] count_o, reload_o;
  logic       tc_o, done_o;

  param_count #(.WIDTH(4), .RST_VAL(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .count_o    (count_o),
    .reload_o   (reload_o),
    .tc_o       (tc_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [3:0] ec;
    logic [3:0] er;
    logic       etc;
    logic       edn;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] ec;
    logic [3:0] er;
    logic       etc;
    logic       edn;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic c, input logic l, input logic [3:0] lv,
                              input logic e, input logic d, input logic [1:0] m,
                              input logic [3:0] ec, input logic [3:0] er,
                              input logic etc, input logic edn);
    vec_t v;
    v.clr = c; v.load = l; v.lv = lv; v.en = e; v.dir = d; v.mode = m;
    v.ec = ec; v.er = er; v.etc = etc; v.edn = edn;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] ec, input logic [3:0] er,
                       input logic etc, input logic edn);
    n_tests++;
    if (count_o !== ec || reload_o !== er || tc_o !== etc || done_o !== edn) begin
      n_fail++;
      $display("FAIL %s: got count=%h reload=%h tc=%b done=%b, want count=%h reload=%h tc=%b done=%b",
               name, count_o, reload_o, tc_o, done_o, ec, er, etc, edn);
    end
  endtask

  // drive one cycle, queue its expectation, compare after the edge
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    clr_i = v.clr; load_i = v.load; load_val_i = v.lv;
    en_i = v.en; dir_i = v.dir; mode_i = v.mode;
    e.name = name; e.ec = v.ec; e.er = v.er; e.etc = v.etc; e.edn = v.edn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(e.name, e.ec, e.er, e.etc, e.edn);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr_i = 0; load_i = 0; load_val_i = 0; en_i = 0; dir_i = 1; mode_i = 0;
    #2;
    check("reset", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 17; k++) begin
      apply($sformatf("wrap_up_%0d", k),
            mk(0, 0, 4'h0, 1, 1, 2'd0, 4'(k % 16), 4'h0, (k == 16), 1'b0));
    end

    vecs.push_back(mk(0, 1, 4'hC, 1, 1, 2'd1, 4'hC, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hD, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hE, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hF, 4'hC, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hC, 4'hC, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hD, 4'hC, 0, 0));
    vecs.push_back(mk(0, 1, 4'h3, 1, 0, 2'd2, 4'h3, 4'h3, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h2, 4'h3, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h1, 4'h3, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h3, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h3, 1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h3, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h3, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h3, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd0, 4'h0, 4'h3, 0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h3, 0, 1));
    vecs.push_back(mk(0, 1, 4'h5, 1, 0, 2'd2, 4'h5, 4'h5, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h4, 4'h5, 0, 0));
    vecs.push_back(mk(0, 1, 4'h7, 0, 1, 2'd0, 4'h7, 4'h7, 0, 0));
    vecs.push_back(mk(1, 1, 4'h9, 1, 1, 2'd0, 4'h0, 4'h7, 0, 0));
    vecs.push_back(mk(0, 1, 4'h9, 1, 1, 2'd0, 4'h9, 4'h9, 0, 0));
    vecs.push_back(mk(0, 1, 4'h8, 0, 1, 2'd0, 4'h8, 4'h8, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd0, 4'h9, 4'h8, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd0, 4'h8, 4'h8, 0, 0));
    vecs.push_back(mk(0, 1, 4'h0, 0, 0, 2'd0, 4'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd0, 4'hF, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd0, 4'hE, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 0, 1, 2'd3, 4'hF, 4'hF, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd3, 4'h0, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'h1, 4'hF, 0, 0));
    vecs.push_back(mk(0, 1, 4'hF, 0, 1, 2'd1, 4'hF, 4'hF, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 2'd1, 4'hF, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 1, 2'd1, 4'hF, 4'hF, 0, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 0, 2'd1, 4'h2, 4'h2, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd1, 4'h1, 4'h2, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd1, 4'h0, 4'h2, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd1, 4'h2, 4'h2, 1, 0));
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 2'd0, 4'h0, 4'h2, 0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 0, 0, 2'd2, 4'h1, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h1, 1, 1));
    vecs.push_back(mk(1, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h1, 0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 2'd2, 4'h0, 4'h1, 1, 1));

    foreach (vecs[i]) apply($sformatf("vec_%0d", i), vecs[i]);

    // asynchronous reset mid-count
    apply("load_a", mk(0, 1, 4'hA, 0, 1, 2'd0, 4'hA, 4'hA, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_rst_count", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset with a finished one-shot
    apply("load_e", mk(0, 1, 4'hE, 0, 1, 2'd2, 4'hE, 4'hE, 0, 0));
    apply("os_f",   mk(0, 0, 4'h0, 1, 1, 2'd2, 4'hF, 4'hE, 0, 0));
    apply("os_done", mk(0, 0, 4'h0, 1, 1, 2'd2, 4'hF, 4'hE, 1, 1));
    #2 rst_n = 1'b0;
    #1 check("async_rst_done", 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
